dds_sweep_ctrl: RTL and testbench
=================================

Name: dds_sweep_ctrl

Overview:
- Sequencer that drives the control inputs of the DDS wrapper (`en_i`, `phase_inc_i`, `phase_offset_i`) to produce a stepped-frequency (chirp) sweep.
- Steps the phase increment from a start value to a stop value by a fixed step, holding each point for a programmable dwell count.
- Supports single-shot or repeating sweeps.
- Sits between the register/config layer and the DDS instance; its outputs connect directly to the DDS inputs.

Parameters:
- PHASE_WIDTH, 14, width of phase increment/offset; must match the DDS.
- DWELL_WIDTH, 16, width of dwell counter/config.
- CNT_WIDTH, 8, width of completed-sweep counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- start_i  in  1  pulse; begins sweep when idle.
- stop_i  in  1  pulse; aborts sweep.
- start_inc_i  in  PHASE_WIDTH  first phase increment (unsigned).
- stop_inc_i  in  PHASE_WIDTH  last phase increment (unsigned).
- step_inc_i  in  PHASE_WIDTH  increment step (unsigned).
- dwell_i  in  DWELL_WIDTH  cycles per point; 0 treated as 1.
- offset_i  in  PHASE_WIDTH  phase offset.
- repeat_i  in  1  1 = restart sweep after the end point.
- bidir_i  in  1  triangle mode; only used with the optional feature.
- en_o  out  1  DDS enable.
- phase_inc_o  out  PHASE_WIDTH  to DDS `phase_inc_i`.
- phase_offset_o  out  PHASE_WIDTH  to DDS `phase_offset_i`.
- point_stb_o  out  1  pulse on the first cycle of each sweep point.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse when a single-shot sweep completes.
- sweep_cnt_o  out  CNT_WIDTH  completed sweeps since last start; wraps.

Behaviour:
- Clock and reset: one clock (`clk_i`); reset `rst_i` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start_i` = 1 and `stop_i` = 0 latches all config inputs into shadow registers and goes to RUN.
  - On the next cycle: `en_o` = 1, `phase_inc_o` = start_inc, `phase_offset_o` = offset, `point_stb_o` = 1, `busy_o` = 1, `sweep_cnt_o` cleared.
  - Latency from `start_i` to outputs: 1 cycle.
- RUN:
  - Each point is held for D = max(dwell, 1) cycles using a dwell counter.
  - At the end of a dwell, if the current point is not the end point: next = current + step, computed in PHASE_WIDTH+1 bits. If next ≥ stop_inc (including overflow), next = stop_inc (clamp). `point_stb_o` pulses.
  - End point is current == stop_inc, or step == 0, or start_inc ≥ stop_inc (single-point sweep).
  - End of dwell on the end point, `repeat_i` = 1: `sweep_cnt_o` += 1 and `phase_inc_o` returns to start_inc with a strobe; no gap, `en_o` stays 1.
  - End of dwell on the end point, `repeat_i` = 0: `sweep_cnt_o` += 1, go to DONE.
- DONE: lasts one cycle with `done_o` = 1, `en_o` = 0, `busy_o` = 0; then IDLE. `phase_inc_o` and `phase_offset_o` hold their last values.
- `stop_i` in RUN or DONE: next cycle is IDLE with `en_o` = 0 and `busy_o` = 0; no `done_o`; `sweep_cnt_o` is held.
- Simultaneous `start_i` and `stop_i`: stop wins; the block stays in or goes to IDLE.
- `start_i` while not IDLE: ignored.
- Config inputs: sampled only on an accepted start; changes mid-sweep have no effect.
- `rst_i` mid-sweep: immediate return to reset values on that edge.

Optional Feature:
- Macro: DDS_SWEEP_BIDIR_EN.
- Defined, `bidir_i` = 1 (triangle sweep):
  - On reaching stop_inc, direction flips to down; the next point is current − step, clamped at start_inc.
  - Reaching start_inc completes one sweep (counter increment; DONE or repeat per `repeat_i`).
  - Turnaround points are not duplicated; each is held for a single dwell.
  - Subtraction uses PHASE_WIDTH+1 bits so underflow clamps to start_inc.
- Not defined: the direction logic is not synthesised and `bidir_i` is ignored; sweeps are up-only.

Test Plan:
- Basic sweep: reset, then start with start=100, stop=130, step=10, dwell=4, repeat=0. Required: `phase_inc_o` = 100, 110, 120, 130, each for 4 cycles from the cycle after start; `point_stb_o` pulses 4 times; `done_o` pulses exactly on cycle 17 after start; `sweep_cnt_o` = 1.
- Clamp: stop=125, step=10, dwell=1. Required sequence 100, 110, 120, 125, then `done_o`. Overflow check: start=16380, stop=16383, step=10, PHASE_WIDTH=14. Required sequence 16380, 16383.
- Repeat and abort: repeat=1, start=0, stop=20, step=10, dwell=0. Required sequence 0, 10, 20, 0, 10, ... with `en_o` continuously 1 and `sweep_cnt_o` incrementing every 3 cycles. A `stop_i` pulse makes `en_o` = 0 next cycle and `done_o` never asserts.
- Edge configs: step=0, or start=50 with stop=40, dwell=3. Required: single point 50 held for 3 cycles, then `done_o`. `start_i` pulsed again mid-sweep: no effect on the sequence.
- Simultaneous events and reset: `start_i` + `stop_i` in IDLE means the block stays IDLE with `en_o` = 0. `rst_i` asserted mid-sweep: all outputs 0 on the next edge. Changing `step_inc_i` mid-sweep: sequence unchanged.
- DDS_SWEEP_BIDIR_EN defined, bidir=1, start=0, stop=30, step=10, dwell=2, repeat=0. Required sequence 0, 10, 20, 30, 20, 10, 0, each for 2 cycles, then `done_o`. With the macro undefined, the same stimulus gives 0, 10, 20, 30 and then `done_o`.

Source files
------------

// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: control/config inputs and DDS-facing outputs of the sweep sequencer
interface dds_sweep_ctrl_if #(
    parameter int PHASE_WIDTH = 14,
    parameter int DWELL_WIDTH = 16,
    parameter int CNT_WIDTH   = 8
);
    logic                   start_i;
    logic                   stop_i;
    logic [PHASE_WIDTH-1:0] start_inc_i;
    logic [PHASE_WIDTH-1:0] stop_inc_i;
    logic [PHASE_WIDTH-1:0] step_inc_i;
    logic [DWELL_WIDTH-1:0] dwell_i;
    logic [PHASE_WIDTH-1:0] offset_i;
    logic                   repeat_i;
    logic                   bidir_i;
    logic                   en_o;
    logic [PHASE_WIDTH-1:0] phase_inc_o;
    logic [PHASE_WIDTH-1:0] phase_offset_o;
    logic                   point_stb_o;
    logic                   busy_o;
    logic                   done_o;
    logic [CNT_WIDTH-1:0]   sweep_cnt_o;

    modport master (
        output start_i, stop_i, start_inc_i, stop_inc_i, step_inc_i, dwell_i, offset_i, repeat_i, bidir_i,
        input  en_o, phase_inc_o, phase_offset_o, point_stb_o, busy_o, done_o, sweep_cnt_o
    );
    modport slave (
        input  start_i, stop_i, start_inc_i, stop_inc_i, step_inc_i, dwell_i, offset_i, repeat_i, bidir_i,
        output en_o, phase_inc_o, phase_offset_o, point_stb_o, busy_o, done_o, sweep_cnt_o
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: stepped-frequency DDS sweep sequencer; define DDS_SWEEP_BIDIR_EN for triangle sweeps
module dds_sweep_ctrl #(
    parameter int PHASE_WIDTH = 14,
    parameter int DWELL_WIDTH = 16,
    parameter int CNT_WIDTH   = 8
) (
    input logic             clk_i,
    input logic             rst_i,
    dds_sweep_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0]             state;
    logic [PHASE_WIDTH-1:0] cur, start_r, stop_r, step_r, off_r, up_nxt, nxt;
    logic [DWELL_WIDTH-1:0] dwell_r, dcnt, dlim;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [PHASE_WIDTH:0]   up_sum;
    logic                   rep_r, stb, accept, advance, degen, sweep_end;

    assign accept  = state == IDLE && bus.start_i && !bus.stop_i;
    assign dlim    = (dwell_r == '0) ? '0 : dwell_r - 1'b1;
    assign advance = state == RUN && !bus.stop_i && dcnt == dlim;
    assign degen   = step_r == '0 || start_r >= stop_r;
    // extra carry bit turns increment overflow into a clamp at the stop value
    assign up_sum  = {1'b0, cur} + {1'b0, step_r};
    assign up_nxt  = (up_sum >= {1'b0, stop_r}) ? stop_r : up_sum[PHASE_WIDTH-1:0];

`ifdef DDS_SWEEP_BIDIR_EN
    logic                   bidir_r, dir, turn;
    logic [PHASE_WIDTH:0]   dn_dif;
    logic [PHASE_WIDTH-1:0] dn_nxt;
    assign dn_dif    = {1'b0, cur} - {1'b0, step_r};
    assign dn_nxt    = (dn_dif[PHASE_WIDTH] || dn_dif[PHASE_WIDTH-1:0] <= start_r) ? start_r : dn_dif[PHASE_WIDTH-1:0];
    assign turn      = bidir_r && !dir && cur == stop_r;
    assign nxt       = (dir || turn) ? dn_nxt : up_nxt;
    assign sweep_end = degen || (bidir_r ? dir && cur == start_r : cur == stop_r);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bidir_r <= 1'b0;
            dir     <= 1'b0;
        end else if (accept) begin
            bidir_r <= bus.bidir_i;
            dir     <= 1'b0;
        end else if (advance) begin
            dir     <= !sweep_end && (dir || turn);
        end
    end
`else
    logic unused_bidir;
    assign unused_bidir = bus.bidir_i;
    assign nxt          = up_nxt;
    assign sweep_end    = degen || cur == stop_r;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cur     <= '0;
            start_r <= '0;
            stop_r  <= '0;
            step_r  <= '0;
            off_r   <= '0;
            dwell_r <= '0;
            rep_r   <= 1'b0;
            dcnt    <= '0;
            cnt     <= '0;
            stb     <= 1'b0;
        end else begin
            stb <= accept || (advance && !(sweep_end && !rep_r));
            if (accept) begin
                state   <= RUN;
                start_r <= bus.start_inc_i;
                stop_r  <= bus.stop_inc_i;
                step_r  <= bus.step_inc_i;
                off_r   <= bus.offset_i;
                dwell_r <= bus.dwell_i;
                rep_r   <= bus.repeat_i;
                cur     <= bus.start_inc_i;
                dcnt    <= '0;
                cnt     <= '0;
            end else if (state != RUN || bus.stop_i) begin
                state <= IDLE;
            end else if (!advance) begin
                dcnt <= dcnt + 1'b1;
            end else if (sweep_end) begin
                dcnt  <= '0;
                cnt   <= cnt + 1'b1;
                cur   <= rep_r ? start_r : cur;
                state <= rep_r ? RUN : DONE;
            end else begin
                dcnt <= '0;
                cur  <= nxt;
            end
        end
    end

    assign bus.en_o           = state == RUN;
    assign bus.busy_o         = state == RUN;
    assign bus.done_o         = state == DONE;
    assign bus.phase_inc_o    = cur;
    assign bus.phase_offset_o = off_r;
    assign bus.point_stb_o    = stb;
    assign bus.sweep_cnt_o    = cnt;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: directed scoreboard bench for the DDS sweep sequencer
module tb_dds_sweep_ctrl;
    localparam int PW = 14, DW = 16, CW = 8;
`ifdef DDS_SWEEP_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    int n_cmp = 0, n_err = 0;
    int q[$];

    dds_sweep_ctrl_if #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
    dds_sweep_ctrl #(.PHASE_WIDTH(PW), .DWELL_WIDTH(DW), .CNT_WIDTH(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int st, input int sp, input int stp, input int dw, input int rep, input int bd);
        bus.start_inc_i = PW'(st);
        bus.stop_inc_i  = PW'(sp);
        bus.step_inc_i  = PW'(stp);
        bus.dwell_i     = DW'(dw);
        bus.offset_i    = PW'(st + 3);
        bus.repeat_i    = rep[0];
        bus.bidir_i     = bd[0];
    endtask

    // expected point list built from integer arithmetic, independent of bit widths
    task automatic model(input int st, input int sp, input int stp, input int bd);
        int c;
        c = st;
        q.push_back(c);
        if (stp != 0 && st < sp) begin
            while (c != sp) begin
                c = (c + stp >= sp) ? sp : c + stp;
                q.push_back(c);
            end
            if (BIDIR && bd != 0)
                while (c != st) begin
                    c = (c - stp <= st) ? st : c - stp;
                    q.push_back(c);
                end
        end
    endtask

    task automatic run(input string nm, input int st, input int sp, input int stp, input int dw, input int bd, input int poke);
        int d, n, c, hold, last, exp;
        d = (dw == 0) ? 1 : dw;
        q.delete();
        model(st, sp, stp, bd);
        n = q.size();
        last = q[n-1];
        cfg(st, sp, stp, dw, 0, bd);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        chk({nm, "_offset"}, 32'(bus.phase_offset_o), st + 3);
        c = 1;
        hold = 0;
        while (!bus.done_o && c < 400) begin
            if (bus.point_stb_o) begin
                if (hold != 0) chk({nm, "_hold"}, hold, d);
                exp = -1;
                if (q.size() != 0) exp = q.pop_front();
                chk({nm, "_phase"}, 32'(bus.phase_inc_o), exp);
                chk({nm, "_en"}, 32'(bus.en_o), 1);
                hold = 1;
            end else hold++;
            if (c == poke) begin
                bus.start_i = 1'b1;
                bus.step_inc_i = PW'(3);
            end else bus.start_i = 1'b0;
            step();
            c++;
        end
        bus.start_i = 1'b0;
        chk({nm, "_done_cycle"}, c, n * d + 1);
        chk({nm, "_hold_last"}, hold, d);
        chk({nm, "_points_left"}, q.size(), 0);
        chk({nm, "_sweep_cnt"}, 32'(bus.sweep_cnt_o), 1);
        chk({nm, "_en_done"}, 32'(bus.en_o), 0);
        chk({nm, "_busy_done"}, 32'(bus.busy_o), 0);
        chk({nm, "_phase_hold"}, 32'(bus.phase_inc_o), last);
        step();
        chk({nm, "_done_pulse"}, 32'(bus.done_o), 0);
    endtask

    initial begin
        int exp;
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        cfg(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_en", 32'(bus.en_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_stb", 32'(bus.point_stb_o), 0);
        chk("rst_phase", 32'(bus.phase_inc_o), 0);
        chk("rst_offset", 32'(bus.phase_offset_o), 0);
        chk("rst_cnt", 32'(bus.sweep_cnt_o), 0);

        run("basic", 100, 130, 10, 4, 0, 0);
        run("clamp", 100, 125, 10, 1, 0, 0);
        run("ovf", 16380, 16383, 10, 1, 0, 0);
        run("step0", 50, 60, 0, 3, 0, 2);
        run("inv", 50, 40, 10, 3, 0, 0);
        run("midchg", 100, 130, 10, 2, 0, 3);
        run("bidir", 0, 30, 10, 2, 1, 0);

        q.delete();
        for (int i = 0; i < 9; i++) q.push_back((i % 3) * 10);
        cfg(0, 20, 10, 0, 1, 0);
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            exp = q.pop_front();
            chk("rep_phase", 32'(bus.phase_inc_o), exp);
            chk("rep_en", 32'(bus.en_o), 1);
            chk("rep_stb", 32'(bus.point_stb_o), 1);
            chk("rep_cnt", 32'(bus.sweep_cnt_o), (c - 1) / 3);
            if (c < 9) step();
        end
        bus.stop_i = 1'b1;
        step();
        bus.stop_i = 1'b0;
        chk("abort_en", 32'(bus.en_o), 0);
        chk("abort_busy", 32'(bus.busy_o), 0);
        chk("abort_cnt", 32'(bus.sweep_cnt_o), 2);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 32'(bus.done_o), 0);
            step();
        end

        cfg(100, 130, 10, 4, 0, 0);
        bus.start_i = 1'b1;
        bus.stop_i  = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        chk("both_en", 32'(bus.en_o), 0);
        chk("both_busy", 32'(bus.busy_o), 0);
        chk("both_stb", 32'(bus.point_stb_o), 0);

        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_phase", 32'(bus.phase_inc_o), 110);
        rst = 1'b1;
        step();
        chk("mid_rst_en", 32'(bus.en_o), 0);
        chk("mid_rst_busy", 32'(bus.busy_o), 0);
        chk("mid_rst_phase", 32'(bus.phase_inc_o), 0);
        chk("mid_rst_offset", 32'(bus.phase_offset_o), 0);
        chk("mid_rst_stb", 32'(bus.point_stb_o), 0);
        chk("mid_rst_cnt", 32'(bus.sweep_cnt_o), 0);
        rst = 1'b0;
        step();
        chk("post_rst_en", 32'(bus.en_o), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
